// File: rtl/rotary_entry_pkg.sv
// rotary_entry_pkg
// Shared types and constants for the rotary value-entry block.
//   entry_state_t : EDIT (digits being edited) / COMMIT (word offered downstream)
//   STEP_FINE     : normal per-detent nibble step
//   STEP_COARSE   : accelerated per-detent nibble step
package rotary_entry_pkg;

    typedef enum logic {
        EDIT   = 1'b0,
        COMMIT = 1'b1
    } entry_state_t;

    localparam logic [3:0] STEP_FINE   = 4'd1;
    localparam logic [3:0] STEP_COARSE = 4'd4;

endpackage

// File: rtl/rotary_value_entry_accel.sv
// rotary_accel
// Rotation acceleration: chooses the nibble step for the current rotation pulse.
// A pulse in the same direction as the previous accepted pulse, arriving while
// the since-last-pulse counter is below ACCEL_WINDOW, gets STEP_COARSE.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears history)
//   pulse      : an accepted rotation pulse this cycle
//   dir_up     : direction of that pulse (1 = increment)
//   clear      : forget history (entry committed); wins over pulse
//   step       : step to apply to the pulse sampled this cycle
module rotary_accel
    import rotary_entry_pkg::*;
#(
    parameter int ACCEL_WINDOW = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse,
    input  logic       dir_up,
    input  logic       clear,
    output logic [3:0] step
);

    localparam int CNT_W = $clog2(ACCEL_WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(ACCEL_WINDOW);

    logic [CNT_W-1:0] cnt;
    logic             have_prev;
    logic             last_up;

    // Counter saturates at the window value; anything at or above it is "slow".
    always_ff @(posedge clk) begin
        if (reset || pulse) begin
            cnt <= '0;
        end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            have_prev <= 1'b0;
        end else if (pulse) begin
            have_prev <= 1'b1;
        end
    end

    // Direction needs no reset: it is only consulted when have_prev is set.
    always_ff @(posedge clk) begin
        if (pulse) begin
            last_up <= dir_up;
        end
    end

    assign step = (have_prev && (last_up == dir_up) && (cnt < CNT_SAT))
                  ? STEP_COARSE : STEP_FINE;

endmodule

// File: rtl/rotary_value_entry.sv
// rotary_value_entry
// Edits a DIGITS-nibble hex word from rotary right/left/down pulses, MSB first,
// and offers the finished word over a valid/ready handshake.
// Optional build macro: ROTARY_ACCEL_EN (fast same-direction turns step by 4).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   right/left   : one-cycle pulses, increment/decrement selected nibble (mod 16)
//   down         : one-cycle pulse, move cursor toward LSB or commit at nibble 0
//   edit_value   : live value under edit
//   cursor       : selected nibble index (0 = LSB)
//   editing      : high in EDIT state
//   value_out    : committed word, stable while value_valid is high
//   value_valid  : committed word offered
//   value_ready  : consumer accepts (transfer on valid && ready)
module rotary_value_entry
    import rotary_entry_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int ACCEL_WINDOW = 2500000
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         right,
    input  logic                                         left,
    input  logic                                         down,
    output logic [4*DIGITS-1:0]                          edit_value,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] cursor,
    output logic                                         editing,
    output logic [4*DIGITS-1:0]                          value_out,
    output logic                                         value_valid,
    input  logic                                         value_ready
);

    localparam int VW = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CUR_TOP = CW'(DIGITS - 1);

    entry_state_t  state, state_nxt;
    logic [VW-1:0] edit_nxt;
    logic [VW-1:0] vout_nxt;
    logic [CW-1:0] cursor_nxt;
    logic          valid_nxt;
    logic [3:0]    nib;
    logic [3:0]    step;
    logic          rot_pulse;
    logic          commit_evt;

    // Simultaneous right+left cancel out and do not count as a pulse.
    assign rot_pulse  = (state == EDIT) && (right ^ left);
    assign commit_evt = (state == EDIT) && down && (cursor == '0);

`ifdef ROTARY_ACCEL_EN
    rotary_accel #(
        .ACCEL_WINDOW (ACCEL_WINDOW)
    ) u_accel (
        .clk    (clk),
        .reset  (reset),
        .pulse  (rot_pulse),
        .dir_up (right),
        .clear  (commit_evt),
        .step   (step)
    );
`else
    assign step = STEP_FINE;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EDIT;
            edit_value  <= '0;
            cursor      <= CUR_TOP;
            value_out   <= '0;
            value_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            edit_value  <= edit_nxt;
            cursor      <= cursor_nxt;
            value_out   <= vout_nxt;
            value_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        edit_nxt   = edit_value;
        cursor_nxt = cursor;
        vout_nxt   = value_out;
        valid_nxt  = value_valid;
        nib        = edit_value[{cursor, 2'b00} +: 4];

        case (state)
            EDIT: begin
                // Nibble arithmetic wraps within 4 bits: no carry/borrow leaks.
                if (rot_pulse) begin
                    edit_nxt[{cursor, 2'b00} +: 4] = right ? (nib + step) : (nib - step);
                end
                // Edit first, then move/commit, so a same-cycle edit is captured.
                if (down) begin
                    if (cursor != '0) begin
                        cursor_nxt = cursor - 1'b1;
                    end else begin
                        vout_nxt  = edit_nxt;
                        valid_nxt = 1'b1;
                        state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (value_ready) begin
                    valid_nxt  = 1'b0;
                    cursor_nxt = CUR_TOP;
                    state_nxt  = EDIT;
                end
            end
            default: state_nxt = EDIT;
        endcase
    end

    assign editing = (state == EDIT);

endmodule

// File: tb/tb_rotary_value_entry.sv
module tb_rotary_value_entry;

    localparam int DIGITS = 4;
    localparam int AW     = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        right = 1'b0;
    logic        left = 1'b0;
    logic        down = 1'b0;
    logic        value_ready = 1'b0;
    logic [15:0] edit_value;
    logic [15:0] value_out;
    logic [1:0]  cursor;
    logic        editing;
    logic        value_valid;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rotary_value_entry #(
        .DIGITS       (DIGITS),
        .ACCEL_WINDOW (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .right       (right),
        .left        (left),
        .down        (down),
        .edit_value  (edit_value),
        .cursor      (cursor),
        .editing     (editing),
        .value_out   (value_out),
        .value_valid (value_valid),
        .value_ready (value_ready)
    );

    // Behavioural reference: digits as an integer array, time as a cycle count.
    int          m_nib[DIGITS];
    int          m_cur;
    bit          m_ed;
    bit          m_vv;
    logic [15:0] m_vo;
    bit          h_prev;
    bit          h_up;
    longint      h_cyc;
    longint      cyc_n = 0;

    function automatic logic [15:0] m_word();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < DIGITS; i++) w[4*i +: 4] = 4'(m_nib[i]);
        return w;
    endfunction

    always @(posedge clk) begin
        int st;
        cyc_n++;
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) m_nib[i] = 0;
            m_cur = DIGITS - 1;
            m_ed = 1; m_vv = 0; m_vo = '0;
            h_prev = 0; h_up = 0; h_cyc = 0;
        end else if (m_ed) begin
            if (right != left) begin
                st = 1;
`ifdef ROTARY_ACCEL_EN
                if (h_prev && (h_up == right) && (cyc_n - h_cyc - 1) < AW) st = 4;
`endif
                if (right) m_nib[m_cur] = (m_nib[m_cur] + st) % 16;
                else       m_nib[m_cur] = (m_nib[m_cur] + 16 - st) % 16;
                h_prev = 1; h_up = right; h_cyc = cyc_n;
            end
            if (down) begin
                if (m_cur > 0) m_cur--;
                else begin
                    m_vo = m_word(); m_vv = 1; m_ed = 0; h_prev = 0;
                end
            end
        end else if (value_ready) begin
            m_vv = 0; m_cur = DIGITS - 1; m_ed = 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("edit_value", 32'(edit_value), 32'(m_word()));
            chk("cursor", 32'(cursor), 32'(m_cur));
            chk("editing", 32'(editing), 32'(m_ed));
            chk("value_valid", 32'(value_valid), 32'(m_vv));
            chk("value_out", 32'(value_out), 32'(m_vo));
        end
    end

    task automatic cyc(input bit r, input bit l, input bit d, input bit rdy);
        right = r; left = l; down = d; value_ready = rdy;
        @(negedge clk);
    endtask

    // Rotation followed by a gap longer than the acceleration window.
    task automatic rot(input bit up);
        cyc(up, !up, 1'b0, 1'b0);
        repeat (15) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic dn();
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_edit"}, 32'(edit_value), 32'h0);
        chk({tag, "_cursor"}, 32'(cursor), 32'd3);
        chk({tag, "_editing"}, 32'(editing), 32'd1);
        chk({tag, "_valid"}, 32'(value_valid), 32'd0);
        chk({tag, "_vout"}, 32'(value_out), 32'h0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk_reset_vals("rst");

        // Three increments on the MSB digit
        repeat (3) rot(1'b1);
        chk("t1_edit", 32'(edit_value), 32'h3000);
        chk("t1_cursor", 32'(cursor), 32'd3);
        chk("t1_valid", 32'(value_valid), 32'd0);

        // Wrap without borrow/carry
        do_reset();
        rot(1'b0);
        chk("t2_borrow", 32'(edit_value), 32'hF000);
        repeat (3) dn();
        rot(1'b0);
        chk("t2_d0F", 32'(edit_value), 32'hF00F);
        rot(1'b1);
        chk("t2_wrap", 32'(edit_value), 32'hF000);
        chk("t2_cursor", 32'(cursor), 32'd0);

        // Enter BEEF, commit with ready low, ignore pulses, then accept
        do_reset();
        repeat (5) rot(1'b0);
        dn();
        repeat (2) rot(1'b0);
        dn();
        repeat (2) rot(1'b0);
        dn();
        rot(1'b0);
        chk("t3_edit", 32'(edit_value), 32'hBEEF);
        dn();
        chk("t3_valid", 32'(value_valid), 32'd1);
        chk("t3_vout", 32'(value_out), 32'hBEEF);
        chk("t3_editing", 32'(editing), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t3_hold_edit", 32'(edit_value), 32'hBEEF);
        chk("t3_hold_vout", 32'(value_out), 32'hBEEF);
        chk("t3_hold_valid", 32'(value_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_acc_valid", 32'(value_valid), 32'd0);
        chk("t3_acc_cursor", 32'(cursor), 32'd3);
        chk("t3_acc_edit", 32'(edit_value), 32'hBEEF);

        // Same-cycle edit and commit; right+left cancel
        repeat (3) dn();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_vout", 32'(value_out), 32'hBEE0);
        chk("t4_valid", 32'(value_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_cancel", 32'(edit_value), 32'hBEE0);

        // Reset drops an offered word
        repeat (4) dn();
        chk("t5_valid", 32'(value_valid), 32'd1);
        do_reset();
        chk_reset_vals("t5");

        // Acceleration: pulses 5 cycles apart, then 20 cycles apart
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef ROTARY_ACCEL_EN
        chk("t6_fast", 32'(edit_value), 32'h5000);
`else
        chk("t6_fast", 32'(edit_value), 32'h2000);
`endif
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (19) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_slow", 32'(edit_value), 32'h2000);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
        end
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
